// File: rtl/axi4_wch_drop_responder_pkg.sv
// Shared definitions for the RAB write-drop path: FSM encodings and AXI response codes.
package axi4_wch_drop_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } drop_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] C_BRESP_DEFAULT = RESP_SLVERR;
    localparam int         DROP_LEN_WIDTH  = 8;

    // A dropped burst ends on whichever comes first: WLAST or the AWLEN-derived final beat.
    function automatic logic is_last_beat(input logic wlast, input logic len_hit);
        return wlast | len_hit;
    endfunction

endpackage

// File: rtl/axi4_wch_drop_responder_fifo.sv
// Pending-drop descriptor queue: power-of-two FIFO with registered occupancy count.
module axi4_drop_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q;
    logic [DEPTH_LOG-1:0] rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi4_wch_drop_responder.sv
// Sinks the W beats of RAB-rejected write bursts and answers each with an error B response.
module axi4_wch_drop_responder
    import axi4_wch_drop_responder_pkg::*;
#(
    parameter int         C_AXI_ID_WIDTH   = 4,
    parameter int         C_AXI_USER_WIDTH = 4,
    parameter int         C_DROP_DEPTH_LOG = 2,
    parameter logic [1:0] C_BRESP          = C_BRESP_DEFAULT
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    input  logic                        drop_valid,
    output logic                        drop_ready,
    input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
    input  logic [C_AXI_USER_WIDTH-1:0] drop_user,
    input  logic [7:0]                  drop_len,
    input  logic                        s_axi4_wvalid,
    input  logic                        s_axi4_wlast,
    output logic                        s_axi4_wready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                  s_axi4_bresp,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                        s_axi4_bvalid,
    input  logic                        s_axi4_bready,
    output logic                        w_len_err
);

    localparam int DESC_W  = C_AXI_ID_WIDTH + C_AXI_USER_WIDTH + DROP_LEN_WIDTH;
    localparam int CNT_W   = C_DROP_DEPTH_LOG + 1;
    localparam int DEPTH   = 1 << C_DROP_DEPTH_LOG;

    drop_state_e                 state_q;
    drop_state_e                 state_d;

    logic [DESC_W-1:0]           fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic [CNT_W-1:0]            fill_next;
    logic                        push;
    logic                        pop;

    logic                        drop_ready_q;
    logic [C_AXI_ID_WIDTH-1:0]   desc_id_q;
    logic [C_AXI_USER_WIDTH-1:0] desc_user_q;
    logic [7:0]                  desc_len_q;
    logic [7:0]                  beat_cnt_q;

    logic                        w_hs;
    logic                        len_hit;
    logic                        w_end;

    logic                        bvalid_q;
    logic [C_AXI_ID_WIDTH-1:0]   bid_q;
    logic [C_AXI_USER_WIDTH-1:0] buser_q;
    logic [1:0]                  bresp_q;
    logic                        w_len_err_q;

    assign push          = drop_valid && drop_ready_q && !fifo_full;
    assign drop_ready    = drop_ready_q;
    assign s_axi4_wready = (state_q == ST_DRAIN);
    assign w_hs          = s_axi4_wvalid && s_axi4_wready;
    assign len_hit       = (beat_cnt_q == desc_len_q);

    assign s_axi4_bvalid = bvalid_q;
    assign s_axi4_bid    = bid_q;
    assign s_axi4_buser  = buser_q;
    assign s_axi4_bresp  = bresp_q;
    assign w_len_err     = w_len_err_q;

    axi4_drop_fifo #(
        .WIDTH     (DESC_W),
        .DEPTH_LOG (C_DROP_DEPTH_LOG)
    ) u_fifo (
        .clk     (axi4_aclk),
        .rst_n   (axi4_arstn),
        .push    (push),
        .wr_data ({drop_id, drop_user, drop_len}),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: combinational logic uses blocking assignments with every output defaulted first,
    // so no latch is inferred on paths that do not assign.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        w_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_hs && is_last_beat(s_axi4_wlast, len_hit)) begin
                    w_end   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Chain straight into the next queued burst so no IDLE bubble appears.
                if (bvalid_q && s_axi4_bready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is registered from the next occupancy so it never depends on this cycle's pop.
    always_comb begin
        fill_next = fifo_count;
        case ({push, pop})
            2'b10:   fill_next = fifo_count + 1'b1;
            2'b01:   fill_next = fifo_count - 1'b1;
            default: fill_next = fifo_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q      <= ST_IDLE;
            drop_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_ready_q <= (fill_next != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            desc_id_q   <= '0;
            desc_user_q <= '0;
            desc_len_q  <= '0;
            beat_cnt_q  <= '0;
        end else if (pop) begin
            {desc_id_q, desc_user_q, desc_len_q} <= fifo_head;
            beat_cnt_q <= '0;
        end else if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            buser_q     <= '0;
            bresp_q     <= '0;
            w_len_err_q <= 1'b0;
        end else begin
            w_len_err_q <= w_end && (s_axi4_wlast != len_hit);
            if (w_end) begin
                bvalid_q <= 1'b1;
                bid_q    <= desc_id_q;
                buser_q  <= desc_user_q;
                bresp_q  <= C_BRESP;
            end else if (bvalid_q && s_axi4_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_wch_drop_responder.sv
// Bench for axi4_wch_drop_responder: transaction-level model, per-cycle compare, B scoreboard.
module tb_axi4_wch_drop_responder;

    logic       axi4_aclk  = 1'b0;
    logic       axi4_arstn = 1'b0;
    logic       drop_valid = 1'b0;
    logic [3:0] drop_id    = '0;
    logic [3:0] drop_user  = '0;
    logic [7:0] drop_len   = '0;
    logic       wvalid     = 1'b0;
    logic       wlast      = 1'b0;
    logic       bready     = 1'b0;
    logic       drop_ready;
    logic       wready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic [3:0] buser;
    logic       bvalid;
    logic       w_len_err;

    always #5 axi4_aclk = ~axi4_aclk;

    axi4_wch_drop_responder dut (
        .axi4_aclk     (axi4_aclk),
        .axi4_arstn    (axi4_arstn),
        .drop_valid    (drop_valid),
        .drop_ready    (drop_ready),
        .drop_id       (drop_id),
        .drop_user     (drop_user),
        .drop_len      (drop_len),
        .s_axi4_wvalid (wvalid),
        .s_axi4_wlast  (wlast),
        .s_axi4_wready (wready),
        .s_axi4_bid    (bid),
        .s_axi4_bresp  (bresp),
        .s_axi4_buser  (buser),
        .s_axi4_bvalid (bvalid),
        .s_axi4_bready (bready),
        .w_len_err     (w_len_err)
    );

    int total = 0;
    int bad   = 0;
    int b_cnt = 0;
    bit rnd_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] id;
        logic [3:0] user;
        logic [7:0] len;
    } desc_t;

    typedef struct {
        int len;
        int p;
    } plan_t;

    desc_t pending[$];
    desc_t exp_b[$];
    plan_t plan[$];
    desc_t cur       = '0;
    bit    cur_valid = 0;
    bit    cur_resp  = 0;
    bit    m_err     = 0;
    bit    m_live    = 0;
    int    cur_beats = 0;
    bit    can_push;
    bit    free_slot;
    bit    by_len;

    // One in-flight transaction at a time; the next queued one starts when the slot frees.
    always @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            pending.delete();
            exp_b.delete();
            cur_valid = 0;
            cur_resp  = 0;
            m_err     = 0;
            m_live    = 0;
        end else begin
            can_push  = m_live && (pending.size() < 4);
            free_slot = !cur_valid;
            m_err     = 0;
            if (cur_valid && !cur_resp && wvalid) begin
                by_len = (cur_beats == int'(cur.len));
                if (wlast || by_len) begin
                    cur_resp = 1;
                    m_err    = (wlast != by_len);
                end else begin
                    cur_beats++;
                end
            end else if (cur_valid && cur_resp && bready) begin
                cur_valid = 0;
                cur_resp  = 0;
                free_slot = 1;
            end
            if (free_slot && pending.size() > 0) begin
                cur       = pending.pop_front();
                cur_valid = 1;
                cur_beats = 0;
            end
            if (drop_valid && can_push) begin
                pending.push_back({drop_id, drop_user, drop_len});
                exp_b.push_back({drop_id, drop_user, drop_len});
            end
            m_live = 1;
        end
    end

    // Per-cycle comparison of every output against the model, one time unit after the edge.
    initial begin
        forever begin
            @(posedge axi4_aclk);
            #1;
            if (axi4_arstn) begin
                check("drop_ready", drop_ready, (m_live && pending.size() < 4));
                check("wready", wready, (cur_valid && !cur_resp));
                check("bvalid", bvalid, (cur_valid && cur_resp));
                check("w_len_err", w_len_err, m_err);
                if (cur_valid && cur_resp) begin
                    check("bid", bid, cur.id);
                    check("buser", buser, cur.user);
                    check("bresp", bresp, 2'b10);
                end
            end
        end
    end

    // B scoreboard: responses must come back in acceptance order.
    desc_t sb_e;
    initial begin
        forever begin
            @(negedge axi4_aclk);
            if (axi4_arstn && bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    fail_now("b_spurious");
                end else begin
                    sb_e = exp_b.pop_front();
                    check("sb_bid", bid, sb_e.id);
                    check("sb_buser", buser, sb_e.user);
                end
                b_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge axi4_aclk);
            #2;
            if (rnd_b) bready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge axi4_aclk);
        #2;
    endtask

    task automatic push(input logic [3:0] id, input logic [3:0] user, input logic [7:0] len);
        bit acc;
        int n = 0;
        drop_valid = 1'b1;
        drop_id    = id;
        drop_user  = user;
        drop_len   = len;
        do begin
            acc = drop_ready;
            tick();
            n++;
        end while (!acc && n < 1000);
        drop_valid = 1'b0;
        if (!acc) fail_now("push_accept");
    endtask

    task automatic send_beat(input bit last);
        bit acc;
        int n = 0;
        wvalid = 1'b1;
        wlast  = last;
        do begin
            acc = wready;
            tick();
            n++;
        end while (!acc && n < 2000);
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!acc) fail_now("w_accept");
    endtask

    task automatic send_burst(input int len, input int p);
        int end_i = (p <= len) ? p : len;
        for (int i = 0; i <= end_i; i++) begin
            send_beat(i == p);
        end
    endtask

    task automatic producer(input int n);
        for (int k = 0; k < n; k++) begin
            int    l;
            int    p;
            plan_t pl;
            repeat ($urandom_range(0, 3)) tick();
            l = $urandom_range(0, 15);
            p = ($urandom_range(0, 7) == 0) ? $urandom_range(0, l + 1) : l;
            push(4'($urandom), 4'($urandom), 8'(l));
            pl.len = l;
            pl.p   = p;
            plan.push_back(pl);
        end
    endtask

    task automatic w_driver(input int n);
        int    got = 0;
        int    w;
        plan_t pl;
        while (got < n) begin
            w = 0;
            while (plan.size() == 0 && w < 3000) begin
                tick();
                w++;
            end
            if (plan.size() == 0) begin
                fail_now("w_plan_wait");
                return;
            end
            pl = plan.pop_front();
            for (int i = 0; i <= ((pl.p <= pl.len) ? pl.p : pl.len); i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(i == pl.p);
            end
            got++;
        end
    endtask

    // ---------------- directed and random sequences ----------------
    int b0;
    int n;

    initial begin
        axi4_arstn = 1'b0;
        repeat (3) tick();
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        axi4_arstn = 1'b1;
        tick();
        check("rst_drop_ready", drop_ready, 1);

        // single-beat burst with stalled response
        b0 = b_cnt;
        push(4'd3, 4'd5, 8'd0);
        n = 0;
        while (!wready && n < 20) begin
            tick();
            n++;
        end
        if (!wready) fail_now("t1_wready");
        send_beat(1'b1);
        check("t1_bvalid", bvalid, 1);
        check("t1_bid", bid, 3);
        check("t1_buser", buser, 5);
        check("t1_bresp", bresp, 2'b10);
        repeat (4) begin
            tick();
            check("t1_hold_bvalid", bvalid, 1);
            check("t1_hold_bid", bid, 3);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t1_bvalid_drop", bvalid, 0);
        check("t1_bcount", b_cnt - b0, 1);

        // fill the queue behind an in-flight burst, then drain back-to-back
        b0 = b_cnt;
        for (int i = 0; i < 5; i++) push(4'(8 + i), 4'(i), 8'd3);
        check("t2_full", drop_ready, 0);
        bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_burst(3, 3);
            if (i < 4) begin
                tick();
                check("t2_no_bubble", wready, 1);
            end
        end
        repeat (4) tick();
        check("t2_bcount", b_cnt - b0, 5);

        // early WLAST
        push(4'd1, 4'd2, 8'd3);
        send_burst(3, 2);
        check("t3_len_err", w_len_err, 1);
        check("t3_bvalid", bvalid, 1);
        tick();
        check("t3_len_err_once", w_len_err, 0);

        // missing WLAST: length counter ends the burst
        push(4'd4, 4'd6, 8'd1);
        send_burst(1, 5);
        check("t4_len_err", w_len_err, 1);
        check("t4_wready", wready, 0);
        tick();
        check("t4_wready_after", wready, 0);
        repeat (2) tick();

        // reset in the middle of a drain with two descriptors queued
        b0 = b_cnt;
        for (int i = 0; i < 3; i++) push(4'(12 + i), 4'd7, 8'd7);
        send_beat(1'b0);
        send_beat(1'b0);
        axi4_arstn = 1'b0;
        #1;
        check("t5_async_wready", wready, 0);
        check("t5_async_bvalid", bvalid, 0);
        tick();
        tick();
        axi4_arstn = 1'b1;
        tick();
        check("t5_drop_ready", drop_ready, 1);
        repeat (6) begin
            check("t5_no_wready", wready, 0);
            check("t5_no_bvalid", bvalid, 0);
            tick();
        end
        check("t5_bcount", b_cnt - b0, 0);

        // randomized traffic
        b0    = b_cnt;
        rnd_b = 1;
        fork
            producer(200);
            w_driver(200);
        join
        n = 0;
        while ((b_cnt - b0) < 200 && n < 3000) begin
            tick();
            n++;
        end
        rnd_b  = 0;
        bready = 1'b1;
        repeat (3) tick();
        check("t6_bcount", b_cnt - b0, 200);
        check("t6_sb_empty", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
